// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a byte-addressed memory, with configurable wait states.
// Define AHB_SLAVE_MEM_ERR_EN to enable the legality check and the two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [2:0]  HSize,
  input  logic        HReadyIn,
  input  logic [31:0] HWData,
  input  logic [3:0]  HWStrb,
  output logic [31:0] HRData,
  output logic        HReadyOut,
  output logic [1:0]  HResp
);

  localparam int AW   = $clog2(MEM_DEPTH);
  localparam int WIDX = (AW > 2) ? AW - 2 : 1;

`ifdef AHB_SLAVE_MEM_ERR_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT} state_t;
`endif

  state_t            state;
  state_t            state_next;
  logic [3:0]        wait_cnt;
  logic              pend;
  logic              pend_write;
  logic [WIDX-1:0]   word_q;
  logic              accept;
  logic              legal;
  logic [31:0]       rd_word;

  logic [7:0] mem [MEM_DEPTH];

  assign accept = HSel & HReadyIn & HTrans[1] & HReadyOut;

`ifdef AHB_SLAVE_MEM_ERR_EN
  logic addr_ok;
  logic size_ok;
  logic align_ok;
  logic unused_bits;
  assign addr_ok     = (HAddr < 32'(MEM_DEPTH));
  assign size_ok     = (HSize <= 3'b010);
  assign align_ok    = !((HSize == 3'b001 && HAddr[0]) ||
                         (HSize == 3'b010 && HAddr[1:0] != 2'b00));
  assign legal       = addr_ok & size_ok & align_ok;
  assign unused_bits = HTrans[0];
`else
  // Without error checking the address wraps and sub-word offsets are ignored.
  logic unused_bits;
  assign legal       = 1'b1;
  assign unused_bits = ^{HAddr[31:AW], HAddr[1:0], HSize, HTrans[0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT: if (wait_cnt == 4'd1) state_next = S_IDLE;
`ifdef AHB_SLAVE_MEM_ERR_EN
      S_ERR1: state_next = S_ERR2;
`endif
      default: begin
        state_next = S_IDLE;
        if (accept) begin
          if (!legal)               state_next = state_t'(2'd2);
          else if (WAIT_STATES > 0) state_next = S_WAIT;
        end
      end
    endcase
  end

  always_comb begin
    HReadyOut = 1'b1;
    HResp     = 2'b00;
    case (state)
      S_WAIT: HReadyOut = 1'b0;
`ifdef AHB_SLAVE_MEM_ERR_EN
      S_ERR1: begin
        HReadyOut = 1'b0;
        HResp     = 2'b01;
      end
      S_ERR2: HResp = 2'b01;
`endif
      default: HReadyOut = 1'b1;
    endcase
  end

  // An accepted transfer stays pending until its data phase completes; errored ones are never pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_write <= 1'b0;
      word_q     <= '0;
      wait_cnt   <= 4'd0;
    end else begin
      if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
      if (HReadyOut) begin
        pend <= accept & legal;
        if (accept) begin
          pend_write <= HWrite;
          word_q     <= HAddr[WIDX+1:2];
          wait_cnt   <= 4'(WAIT_STATES);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pend && pend_write && state == S_IDLE) begin
      for (int j = 0; j < 4; j++) begin
        if (HWStrb[j]) mem[AW'({word_q, 2'(j)})] <= HWData[8*j +: 8];
      end
    end
  end

  always_comb begin
    rd_word = 32'd0;
    for (int j = 0; j < 4; j++) begin
      rd_word[8*j +: 8] = mem[AW'({word_q, 2'(j)})];
    end
  end

  assign HRData = (pend && !pend_write) ? rd_word : 32'd0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one instance with no wait states, one with three.
// The error-response steps follow AHB_SLAVE_MEM_ERR_EN, matching the RTL build.
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel0, sel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready_in;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3;
  logic [1:0]  resp0, resp3;

  int errors = 0;
  int checks = 0;
  int ncyc;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  always #5 clk = ~clk;

  assign hready_in = sel3 ? ready3 : ready0;

  ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .HSel(sel0), .HAddr(haddr), .HTrans(htrans),
    .HWrite(hwrite), .HSize(hsize), .HReadyIn(hready_in), .HWData(hwdata),
    .HWStrb(hwstrb), .HRData(rdata0), .HReadyOut(ready0), .HResp(resp0)
  );

  ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .HSel(sel3), .HAddr(haddr), .HTrans(htrans),
    .HWrite(hwrite), .HSize(hsize), .HReadyIn(hready_in), .HWData(hwdata),
    .HWStrb(hwstrb), .HRData(rdata3), .HReadyOut(ready3), .HResp(resp3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                               input logic write, input logic [31:0] wdata,
                               input logic [3:0] strb);
    haddr  = addr;
    htrans = trans;
    hwrite = write;
    hsize  = 3'b010;
    hwdata = wdata;
    hwstrb = strb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel0  = 1'b1;
    sel3  = 1'b0;
    applyStimulus(32'h0, IDLE, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 256; i++) begin
      dut0.mem[i] = (i < 72) ? 8'(2 * i) : 8'h00;
      dut3.mem[i] = (i < 72) ? 8'(2 * i) : 8'h00;
    end
    #12;
    checkOutput("reset_ready", 32'(ready0), 32'd1);
    checkOutput("reset_resp", 32'(resp0), 32'd0);
    checkOutput("reset_rdata", rdata0, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] word read at 0x04, no wait states");
    applyStimulus(32'h04, NONSEQ, 1'b0, 32'h0, 4'h0);
    step();
    applyStimulus(32'h0, IDLE, 1'b0, 32'h0, 4'h0);
    checkOutput("rd04_data", rdata0, 32'h0E0C0A08);
    checkOutput("rd04_ready", 32'(ready0), 32'd1);
    checkOutput("rd04_resp", 32'(resp0), 32'd0);
    step();

    $display("[TB] strobed write to 0x10 then back-to-back read");
    applyStimulus(32'h10, NONSEQ, 1'b1, 32'h0, 4'h0);
    step();
    applyStimulus(32'h10, NONSEQ, 1'b0, 32'hDEADBEEF, 4'b0011);
    checkOutput("wr10_ready", 32'(ready0), 32'd1);
    step();
    applyStimulus(32'h0, IDLE, 1'b0, 32'h0, 4'h0);
    checkOutput("rd10_data", rdata0, 32'h2624BEEF);
    checkOutput("mem12", 32'(dut0.mem[8'h12]), 32'h24);
    checkOutput("mem13", 32'(dut0.mem[8'h13]), 32'h26);
    step();

`ifdef AHB_SLAVE_MEM_ERR_EN
    $display("[TB] illegal read at 0x102 and write at 0x100");
    applyStimulus(32'h102, NONSEQ, 1'b0, 32'h0, 4'h0);
    step();
    checkOutput("err1_ready", 32'(ready0), 32'd0);
    checkOutput("err1_resp", 32'(resp0), 32'd1);
    checkOutput("err1_rdata", rdata0, 32'd0);
    step();
    checkOutput("err2_ready", 32'(ready0), 32'd1);
    checkOutput("err2_resp", 32'(resp0), 32'd1);
    applyStimulus(32'h100, NONSEQ, 1'b1, 32'h0, 4'h0);
    step();
    applyStimulus(32'h0, IDLE, 1'b0, 32'hCAFEF00D, 4'hF);
    checkOutput("wrerr1_resp", 32'(resp0), 32'd1);
    checkOutput("wrerr1_ready", 32'(ready0), 32'd0);
    step();
    checkOutput("wrerr2_resp", 32'(resp0), 32'd1);
    step();
    checkOutput("after_err_resp", 32'(resp0), 32'd0);
    checkOutput("mem0_kept", {dut0.mem[3], dut0.mem[2], dut0.mem[1], dut0.mem[0]}, 32'h06040200);
`else
    $display("[TB] out-of-range read at 0x102 wraps to word 0x00");
    applyStimulus(32'h102, NONSEQ, 1'b0, 32'h0, 4'h0);
    step();
    applyStimulus(32'h0, IDLE, 1'b0, 32'h0, 4'h0);
    checkOutput("wrap_data", rdata0, 32'h06040200);
    checkOutput("wrap_resp", 32'(resp0), 32'd0);
    checkOutput("wrap_ready", 32'(ready0), 32'd1);
    step();
`endif

    $display("[TB] IDLE transfers with slave selected");
    applyStimulus(32'h10, IDLE, 1'b1, 32'hFFFFFFFF, 4'hF);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("idle_ready", 32'(ready0), 32'd1);
      checkOutput("idle_resp", 32'(resp0), 32'd0);
    end
    checkOutput("idle_mem10", {dut0.mem[8'h13], dut0.mem[8'h12], dut0.mem[8'h11], dut0.mem[8'h10]},
                32'h2624BEEF);

    $display("[TB] 4-beat burst with three wait states");
    sel0 = 1'b0;
    sel3 = 1'b1;
    applyStimulus(32'h0, NONSEQ, 1'b0, 32'h0, 4'h0);
    step();
    ncyc = 1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("burst%0d_wait%0d", b, k), 32'(ready3), 32'd0);
        step();
        ncyc++;
      end
      checkOutput($sformatf("burst%0d_ready", b), 32'(ready3), 32'd1);
      checkOutput($sformatf("burst%0d_data", b), rdata3,
                  {8'(8 * b + 6), 8'(8 * b + 4), 8'(8 * b + 2), 8'(8 * b)});
      if (b < 3) applyStimulus(32'(4 * (b + 1)), SEQ, 1'b0, 32'h0, 4'h0);
      else       applyStimulus(32'h0, IDLE, 1'b0, 32'h0, 4'h0);
      if (b < 3) begin
        step();
        ncyc++;
      end
    end
    checkOutput("burst_cycles", 32'(ncyc), 32'd16);
    step();

    $display("[TB] reset during wait state of a write to 0x20");
    applyStimulus(32'h20, NONSEQ, 1'b1, 32'h0, 4'h0);
    step();
    applyStimulus(32'h0, IDLE, 1'b0, 32'h12345678, 4'hF);
    checkOutput("rstwr_wait", 32'(ready3), 32'd0);
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("rstwr_ready", 32'(ready3), 32'd1);
    checkOutput("rstwr_resp", 32'(resp3), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checkOutput("rstwr_mem20", {dut3.mem[8'h23], dut3.mem[8'h22], dut3.mem[8'h21], dut3.mem[8'h20]},
                32'h46444240);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite responder (slave) backed by a byte-addressed memory array. It is the completion side of the master port of the DMA controller: it accepts pipelined address/data phases from the DMA, inserts wait states and commits byte-strobed writes. It also returns read data and flags illegal accesses with a two-cycle ERROR response. It serves as the synthesizable source/destination peripheral in DMA system benches and as a simple on-chip SRAM slave.

Parameters:
MEM_DEPTH, 256, memory size in bytes; power of two, minimum 4.
WAIT_STATES, 0, HReadyOut-low cycles inserted in each OKAY data phase (0..15).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
HSel  input  1  slave select.
HAddr  input  32  byte address (address phase).
HTrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
HWrite  input  1  1 = write (address phase).
HSize  input  3  000 byte, 001 halfword, 010 word; others illegal.
HReadyIn  input  1  bus-level ready; an address phase is accepted only when high.
HWData  input  32  write data (data phase).
HWStrb  input  4  byte-lane write strobes (data phase, sampled with HWData).
HRData  output  32  read data (data phase).
HReadyOut  output  1  data phase completes when high.
HResp  output  2  00 OKAY, 01 ERROR.

Behaviour:
- Reset: asynchronous assertion forces FSM to IDLE, HReadyOut=1, HResp=00, HRData=0, and clears latched address/control. Memory contents are not reset; benches preload through the hierarchical array named mem, which is byte-indexed 0..MEM_DEPTH-1.
- Address phase accept: HSel & HReadyIn & HTrans[1] & HReadyOut on a rising edge. On accept, latch HAddr, HWrite and HSize.
- IDLE/BUSY, or an unselected slave: no transfer; the next data phase is OKAY with zero wait states.
- Legality check at accept: HAddr < MEM_DEPTH, HSize <= 010, and alignment (halfword requires HAddr[0]=0; word requires HAddr[1:0]=00). If any check fails, the FSM goes to ERR1.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HReadyOut=1, HResp=00. A legal accept with WAIT_STATES=0 stays in IDLE and completes the data phase in the next cycle. A legal accept with WAIT_STATES>0 loads the counter and goes to WAIT.
  - WAIT: HReadyOut=0, HResp=00. The counter decrements each cycle. When it reaches 1, the FSM returns to IDLE and the data phase completes in the following cycle. Total data phase = WAIT_STATES+1 cycles.
  - ERR1: HReadyOut=0, HResp=01, then ERR2.
  - ERR2: HReadyOut=1, HResp=01, then IDLE. A new address phase presented in ERR2 is accepted.
- Write commit: on the completing data-phase edge (HReadyOut=1, OKAY), for each j with HWStrb[j]=1, write mem[{addr[31:2],2'bj}] = HWData[8j+7:8j]. Lanes with strobe 0 are untouched. Strobe/HSize mismatch is not checked; the strobes govern.
- Errored transfers never write.
- Read data: during a read data phase, HRData = {mem[a+3],mem[a+2],mem[a+1],mem[a]}, little-endian, with a = word-aligned latched address. It is combinational from the array, so a read immediately following a write to the same word returns the new data. HRData=0 outside read data phases and during ERROR.
- Pipelining: a new address phase may be accepted in the same cycle the previous data phase completes. Back-to-back NONSEQ/SEQ transfers therefore sustain one transfer per WAIT_STATES+1 cycles.
- Reset mid-transfer: a pending write is discarded and the FSM returns to IDLE immediately.

Optional Feature:
AHB_SLAVE_MEM_ERR_EN
- Defined: the legality check and the ERR1/ERR2 states are present as described.
- Undefined: no ERROR responses are generated and HResp is tied to 00. The address is taken modulo MEM_DEPTH (wrap-around) and misaligned accesses use the word-aligned address. ERR states are not implemented.

Test Plan:
- Reset, WAIT_STATES=0; preload mem[i]=2i for i<72; read word at 0x04 -> HRData=0x0E0C0A08, HReadyOut=1 in the data phase, HResp=00.
- Write 0xDEADBEEF to 0x10 with HWStrb=0011, then read 0x10 back-to-back -> HRData=0x2624BEEF; mem[0x12], mem[0x13] unchanged.
- WAIT_STATES=3, 4-beat SEQ word reads from 0x00 -> each data phase has HReadyOut low 3 cycles, then high; burst completes in 16 cycles after the first accept.
- With AHB_SLAVE_MEM_ERR_EN, word read at 0x102 (MEM_DEPTH=256) -> ERR1 (HReadyOut=0, HResp=01), then ERR2 (HReadyOut=1, HResp=01); a write to 0x100 leaves memory unchanged. Without the macro, the 0x102 read returns the word at 0x00 with OKAY.
- Assert rst_n low during the WAIT state of a write to 0x20 -> HReadyOut=1 and HResp=00 immediately; mem[0x20..0x23] keeps its old value.
- HTrans=IDLE with HSel=1 for 5 cycles -> HReadyOut stays 1, HResp=00, no memory change.
